div_mult_seq: RTL and testbench
===============================

Name: div_mult_seq

Overview:
Multicycle sequencer for the MULT/DIV resource feeding the HI/LO registers of the multicycle CPU.
- Accepts a start pulse from control_unit with operands from registers A and B.
- Iterates one radix-2 step per clock: Booth for signed multiply, restoring divide on magnitudes for signed divide.
- Reports completion or divide-by-zero back to control_unit.
- control_unit uses done to assert the Hi/Lo load enables.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = MULT, 1 = DIV
a_in  input  WIDTH  multiplicand / dividend (register A)
b_in  input  WIDTH  multiplier / divisor (register B)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: hi_out/lo_out valid
div_zero_exc  output  1  one-cycle pulse: DIV with b_in == 0
hi_out  output  WIDTH  MULT: product[63:32]; DIV: remainder
lo_out  output  WIDTH  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - busy, done, div_zero_exc are 0.
  - hi_out, lo_out and all internal registers are 0.
  - Reset mid-operation aborts immediately; no done is issued.
- States: IDLE, MUL_RUN, DIV_RUN, DIV_FIX, FINISH.
- IDLE, start=1 at edge k:
  - Operands and op are latched.
  - Counter is loaded with WIDTH.
  - If op=1 and b_in==0, go to FINISH with the zero flag set; otherwise go to MUL_RUN or DIV_RUN.
- MUL_RUN (Booth radix-2): register {P[2*WIDTH:0]} = {0, b, 0}.
  - Each cycle, examine P[1:0]: 01 adds a to the upper half, 10 subtracts a, otherwise no change.
  - Then arithmetic shift right by 1.
  - Counter decrements; at 1, go to FINISH.
- DIV_RUN: operate on |a| and |b|.
  - Each cycle, shift {R,Q} left by 1 and trial-subtract |b| from R.
  - If non-negative, keep the result and set Q[0]=1; else restore R and set Q[0]=0.
  - Counter at 1, go to DIV_FIX.
- DIV_FIX, one cycle:
  - Quotient is negated if sign(a) != sign(b).
  - Remainder is negated if a is negative, so it takes the dividend's sign (truncation toward zero).
- FINISH, one cycle:
  - done=1; hi_out/lo_out are written at entry and hold until the next accepted start.
  - On divide-by-zero: div_zero_exc=1 together with done=1, and hi_out/lo_out stay unchanged.
  - Next state is IDLE.
- Latency with start at edge k:
  - busy=1 from k+1 through the cycle before done.
  - MULT: done at cycle k+WIDTH+1 (33).
  - DIV: done at cycle k+WIDTH+2 (34).
  - Divide-by-zero: done and div_zero_exc at k+1.
- busy=0 in IDLE and FINISH.
- start while not IDLE is ignored; it is not queued.
- op and operand changes after the start edge have no effect.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraparound, no exception).
- MULT result is the exact signed 64-bit product; no overflow flag.
- Arithmetic in DIV_RUN uses a WIDTH+1 bit R to hold the trial-subtract sign.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding localparams (IDLE, MUL_RUN, DIV_RUN, DIV_FIX, FINISH);
  - OP_MULT=1'b0, OP_DIV=1'b1.
- One natural sub-module: div_restore_step.
  - Combinational shift / trial-subtract / restore for one quotient bit.
  - Instantiated once per cycle in DIV_RUN.
- Booth step remains inline.

Test Plan:
- MULT 7 x -3 (a=7, b=0xFFFFFFFD) -> done at k+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
- DIV 100 / 7 -> done at k+34; lo=14, hi=2. Then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5 / 0 -> at k+1 done=1 and div_zero_exc=1 for one cycle; hi/lo keep their prior values; busy never high.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero_exc=0. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- start pulses at k+5 and k+20 during a MULT -> ignored; single done at k+33 with the original result.
- reset driven low at k+10 mid-DIV -> busy, done, hi, lo go to 0 asynchronously; after release, a fresh MULT 3 x 4 gives lo=12, hi=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the MULT/DIV sequencer feeding HI/LO.
//   state_t : sequencer states
//   OP_MULT / OP_DIV : encoding of the op input from control_unit
package cpu_pkg;

  // state   | meaning
  // IDLE    | waiting for start
  // MUL_RUN | one Booth radix-2 step per clock
  // DIV_RUN | one restoring-divide step per clock on magnitudes
  // DIV_FIX | apply result signs (truncation toward zero)
  // FINISH  | done pulse; HI/LO valid
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_RUN = 3'd1,
    DIV_RUN = 3'd2,
    DIV_FIX = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-divide iteration, purely combinational.
//   rem, quo      : current partial remainder and dividend/quotient shift register
//   divisor       : divisor magnitude
//   rem_next, quo_next : values after shifting in one dividend bit and
//                        producing one quotient bit
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The extra top bit of trial carries the sign of the trial subtraction.
  // A restored remainder never needs bit WIDTH: if shifted reached 2^WIDTH
  // it would already exceed the divisor and not be restored.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_mult_seq.sv
// Multicycle MULT/DIV sequencer for the HI/LO registers.
//   clk, reset (async, active low)
//   start, op, a_in, b_in : request from control_unit, sampled only in IDLE
//   busy          : operation in progress
//   done          : one-cycle pulse, hi_out/lo_out valid
//   div_zero_exc  : one-cycle pulse with done for DIV by zero
//   hi_out/lo_out : MULT product high/low, or DIV remainder/quotient
module div_mult_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero_exc,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  // Booth register carries one guard bit above the accumulator so that a
  // multiplicand of -2^(WIDTH-1) cannot overflow the add/subtract.
  logic [2*WIDTH+1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               neg_q;
  logic               neg_r;

  logic [WIDTH:0]     acc;
  logic [WIDTH:0]     acc_next;
  logic [WIDTH:0]     a_ext;
  logic [2*WIDTH+1:0] prod_next;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               cnt_last;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  always_comb begin
    a_ext = {mcand[WIDTH-1], mcand};
    acc   = prod[2*WIDTH+1:WIDTH+1];
    case (prod[1:0])
      2'b01:   acc_next = acc + a_ext;
      2'b10:   acc_next = acc - a_ext;
      default: acc_next = acc;
    endcase
    prod_next = $signed({acc_next, prod[WIDTH:0]}) >>> 1;
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign cnt_last = (cnt == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mcand        <= '0;
      prod         <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      hi_out       <= '0;
      lo_out       <= '0;
    end else begin
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= CW'(WIDTH);
            if (op == OP_DIV) begin
              rem   <= '0;
              quo   <= mag(a_in);
              dvs   <= mag(b_in);
              neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              neg_r <= a_in[WIDTH-1];
              if (b_in == '0) begin
                state        <= FINISH;
                done         <= 1'b1;
                div_zero_exc <= 1'b1;
              end else begin
                state <= DIV_RUN;
                busy  <= 1'b1;
              end
            end else begin
              mcand <= a_in;
              prod  <= {{(WIDTH+1){1'b0}}, b_in, 1'b0};
              state <= MUL_RUN;
              busy  <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          prod <= prod_next;
          cnt  <= cnt - CW'(1);
          if (cnt_last) begin
            hi_out <= prod_next[2*WIDTH:WIDTH+1];
            lo_out <= prod_next[WIDTH:1];
            state  <= FINISH;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        DIV_RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - CW'(1);
          if (cnt_last) state <= DIV_FIX;
        end
        DIV_FIX: begin
          lo_out <= neg_q ? -quo : quo;
          hi_out <= neg_r ? -rem : rem;
          state  <= FINISH;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mult_seq.sv
module tb_div_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, div_zero_exc;
  logic [31:0] hi_out, lo_out;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  div_mult_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .op           (op),
    .a_in         (a_in),
    .b_in         (b_in),
    .busy         (busy),
    .done         (done),
    .div_zero_exc (div_zero_exc),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles-to-done countdown and result from plain
  // 64-bit signed arithmetic.
  int          m_cnt = 0;
  logic        exp_busy = 0, exp_done = 0, exp_dz = 0;
  logic [31:0] exp_hi = 0, exp_lo = 0, p_hi = 0, p_lo = 0;

  always @(posedge clk or negedge rst_n) begin
    longint sa, sb, r;
    if (!rst_n) begin
      m_cnt = 0; exp_busy = 0; exp_done = 0; exp_dz = 0; exp_hi = 0; exp_lo = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        exp_busy = 0; exp_done = 1; exp_hi = p_hi; exp_lo = p_lo;
      end
    end else if (exp_done) begin
      exp_done = 0; exp_dz = 0;
    end else if (start) begin
      sa = longint'($signed(a_in));
      sb = longint'($signed(b_in));
      if (op && b_in == 0) begin
        exp_done = 1; exp_dz = 1;
      end else if (op) begin
        r = sa / sb; p_lo = r[31:0];
        r = sa % sb; p_hi = r[31:0];
        m_cnt = 33; exp_busy = 1;
      end else begin
        r = sa * sb; p_hi = r[63:32]; p_lo = r[31:0];
        m_cnt = 32; exp_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("done", {63'd0, done}, {63'd0, exp_done});
      chk("div_zero_exc", {63'd0, div_zero_exc}, {63'd0, exp_dz});
      chk("hi_lo", {hi_out, lo_out}, {exp_hi, exp_lo});
    end
  end

  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int lat, output int bcnt, output logic dz);
    @(negedge clk);
    start = 1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 0; op = $urandom; a_in = $urandom; b_in = $urandom;
    lat = 0; bcnt = 0; dz = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
      start = inject && (lat == 5 || lat == 20);
      a_in = $urandom; b_in = $urandom;
    end
    start = 0;
    if (!done) chk("done_timeout", 64'(lat), 64'd0);
    dz = div_zero_exc;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      4: return -32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc;
    logic dz;
    #1 rst_n = 0;
    #18 rst_n = 1;
    @(negedge clk);
    cmp_en = 1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi_out, lo_out}, 64'd0);

    run_op(0, 32'd7, 32'hFFFF_FFFD, 0, lat, bc, dz);
    chk("mul7x-3_lat", 64'(lat), 64'd32);
    chk("mul7x-3_busy_cycles", 64'(bc), 64'd32);
    chk("mul7x-3", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(1, 32'd100, 32'd7, 0, lat, bc, dz);
    chk("div100/7_lat", 64'(lat), 64'd33);
    chk("div100/7", {hi_out, lo_out}, {32'd2, 32'd14});

    run_op(1, 32'hFFFF_FFF9, 32'd2, 0, lat, bc, dz);
    chk("div-7/2", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(1, 32'd5, 32'd0, 0, lat, bc, dz);
    chk("div0_lat", 64'(lat), 64'd0);
    chk("div0_exc", {63'd0, dz}, 64'd1);
    chk("div0_busy_cycles", 64'(bc), 64'd0);
    chk("div0_hilo_hold", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bc, dz);
    chk("div_ovf", {hi_out, lo_out}, {32'd0, 32'h8000_0000});
    chk("div_ovf_exc", {63'd0, dz}, 64'd0);

    run_op(0, 32'h8000_0000, 32'h8000_0000, 0, lat, bc, dz);
    chk("mul_min_min", {hi_out, lo_out}, 64'h4000_0000_0000_0000);

    run_op(0, 32'h1234, 32'hFFFF_FFFB, 1, lat, bc, dz);
    chk("mul_inject_lat", 64'(lat), 64'd32);
    chk("mul_inject", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_A4FC);

    // Abort a divide with an asynchronous reset in mid-cycle.
    @(negedge clk);
    start = 1; op = 1; a_in = 32'd100; b_in = 32'd7;
    @(negedge clk);
    start = 0;
    repeat (9) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    run_op(0, 32'd3, 32'd4, 0, lat, bc, dz);
    chk("mul3x4", {hi_out, lo_out}, 64'd12);

    // Random traffic; the per-cycle compare against the model does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom % 6) == 0;
      op    = $urandom;
      a_in  = rnd_opnd();
      b_in  = rnd_opnd();
    end
    @(negedge clk);
    start = 0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
